// File: rtl/sdram_arbit_if.sv
// +----------------------------------------------------------------------------+
// | sdram_arbit_if : source-side and pin-side signals of the SDRAM arbiter     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface sdram_arbit_if;
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [11:0] init_addr;
    logic        aref_en;
    logic        aref_end;
    logic [3:0]  aref_cmd;
    logic [11:0] aref_addr;
    logic        wr_req;
    logic        wr_en;
    logic        wr_end;
    logic [3:0]  wr_cmd;
    logic [11:0] wr_addr;
    logic [1:0]  wr_bank;
    logic        rd_req;
    logic        rd_en;
    logic        rd_end;
    logic [3:0]  rd_cmd;
    logic [11:0] rd_addr;
    logic [1:0]  rd_bank;
    logic        ref_pend;
    logic [3:0]  sdram_cmd;
    logic [11:0] sdram_addr;
    logic [1:0]  sdram_bank;

    // Arbiter view
    modport slave (
        input  init_end, init_cmd, init_addr,
        output aref_en,
        input  aref_end, aref_cmd, aref_addr,
        input  wr_req,
        output wr_en,
        input  wr_end, wr_cmd, wr_addr, wr_bank,
        input  rd_req,
        output rd_en,
        input  rd_end, rd_cmd, rd_addr, rd_bank,
        output ref_pend, sdram_cmd, sdram_addr, sdram_bank
    );

    // Command-source / pin view
    modport master (
        output init_end, init_cmd, init_addr,
        input  aref_en,
        output aref_end, aref_cmd, aref_addr,
        output wr_req,
        input  wr_en,
        output wr_end, wr_cmd, wr_addr, wr_bank,
        output rd_req,
        input  rd_en,
        output rd_end, rd_cmd, rd_addr, rd_bank,
        input  ref_pend, sdram_cmd, sdram_addr, sdram_bank
    );
endinterface

`default_nettype wire

// File: rtl/sdram_arbit.sv
// +----------------------------------------------------------------------------+
// | sdram_arbit : SDRAM command arbiter, refresh timer and registered pin mux  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sdram_arbit #(
    parameter int REF_CNT_MAX = 780
) (
    input  logic          sclk,
    input  logic          s_rst_n,
    sdram_arbit_if.slave  bus
);

    localparam int          c_CNT_W    = (REF_CNT_MAX > 1) ? $clog2(REF_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(REF_CNT_MAX - 1);
    localparam logic [3:0]  c_CMD_NOP  = 4'b0111;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_ref_cnt;
    logic                 r_ref_pend;
    logic                 r_last_wr;
    logic                 w_wrap;
    logic                 w_gnt_aref;
    logic                 w_gnt_wr;
    logic                 w_gnt_rd;
    logic [3:0]           w_cmd;
    logic [11:0]          w_addr;
    logic [1:0]           w_bank;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) r_state <= ST_INIT;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd       = c_CMD_NOP;
        w_addr      = 12'd0;
        w_bank      = 2'd0;
        case (r_state)
            ST_INIT: begin
                w_cmd  = bus.init_cmd;
                w_addr = bus.init_addr;
                if (bus.init_end) w_state_nxt = ST_ARBIT;
            end
            ST_ARBIT: begin
                // Refresh first; on a write/read tie, alternate from the last grant
                if (r_ref_pend)                    w_state_nxt = ST_AREF;
                else if (bus.wr_req && bus.rd_req) w_state_nxt = r_last_wr ? ST_READ : ST_WRITE;
                else if (bus.wr_req)               w_state_nxt = ST_WRITE;
                else if (bus.rd_req)               w_state_nxt = ST_READ;
            end
            ST_AREF: begin
                w_cmd  = bus.aref_cmd;
                w_addr = bus.aref_addr;
                if (bus.aref_end) w_state_nxt = ST_ARBIT;
            end
            ST_WRITE: begin
                w_cmd  = bus.wr_cmd;
                w_addr = bus.wr_addr;
                w_bank = bus.wr_bank;
                if (bus.wr_end) w_state_nxt = ST_ARBIT;
            end
            ST_READ: begin
                w_cmd  = bus.rd_cmd;
                w_addr = bus.rd_addr;
                w_bank = bus.rd_bank;
                if (bus.rd_end) w_state_nxt = ST_ARBIT;
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    assign w_gnt_aref = (r_state == ST_ARBIT) && (w_state_nxt == ST_AREF);
    assign w_gnt_wr   = (r_state == ST_ARBIT) && (w_state_nxt == ST_WRITE);
    assign w_gnt_rd   = (r_state == ST_ARBIT) && (w_state_nxt == ST_READ);
    assign w_wrap     = (r_state != ST_INIT) && (r_ref_cnt == c_CNT_LAST);

    // A wrap coinciding with a refresh grant re-arms the request rather than losing it
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_ref_cnt  <= '0;
            r_ref_pend <= 1'b0;
        end else begin
            if (r_state == ST_INIT || w_wrap) r_ref_cnt <= '0;
            else                              r_ref_cnt <= r_ref_cnt + 1'b1;
            if (w_wrap)          r_ref_pend <= 1'b1;
            else if (w_gnt_aref) r_ref_pend <= 1'b0;
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_last_wr      <= 1'b0;
            bus.aref_en    <= 1'b0;
            bus.wr_en      <= 1'b0;
            bus.rd_en      <= 1'b0;
            bus.sdram_cmd  <= c_CMD_NOP;
            bus.sdram_addr <= 12'd0;
            bus.sdram_bank <= 2'd0;
        end else begin
            if (w_gnt_wr)      r_last_wr <= 1'b1;
            else if (w_gnt_rd) r_last_wr <= 1'b0;
            bus.aref_en    <= w_gnt_aref;
            bus.wr_en      <= w_gnt_wr;
            bus.rd_en      <= w_gnt_rd;
            bus.sdram_cmd  <= w_cmd;
            bus.sdram_addr <= w_addr;
            bus.sdram_bank <= w_bank;
        end
    end

    assign bus.ref_pend = r_ref_pend;

endmodule

`default_nettype wire

// File: doc/sdram_arbit.md
# sdram_arbit

SDRAM command arbiter and scheduler for the 100 MHz SDRAM subsystem. Sits between the SDRAM pins and four command sources: power-up init, auto-refresh, burst write and burst read. It generates the periodic refresh request and grants the bus to exactly one source at a time, with priority refresh > write/read. It multiplexes the granted source's command, address and bank onto registered SDRAM outputs.

## Interface
Parameters:
- REF_CNT_MAX, 780, refresh interval in sclk cycles (7.8 us at 100 MHz).

Ports (command encoding {cs_n,ras_n,cas_n,we_n}; NOP = 4'b0111):
- sclk  in  1  system clock, 100 MHz
- s_rst_n  in  1  reset; asynchronous, active-low
- init_end  in  1  init sequence complete (level or pulse)
- init_cmd / init_addr  in  4 / 12  init command, address
- aref_en  out  1  refresh grant pulse
- aref_end  in  1  refresh done strobe
- aref_cmd / aref_addr  in  4 / 12  refresh command, address
- wr_req  in  1  write request, level, held until wr_en
- wr_en  out  1  write grant pulse
- wr_end  in  1  write done strobe
- wr_cmd / wr_addr / wr_bank  in  4 / 12 / 2  write command, address, bank
- rd_req / rd_en / rd_end  in / out / in  1  read request, grant, done (same rules as write)
- rd_cmd / rd_addr / rd_bank  in  4 / 12 / 2  read command, address, bank
- ref_pend  out  1  refresh pending; write/read engines end after the current burst when high
- sdram_cmd / sdram_addr / sdram_bank  out  4 / 12 / 2  registered SDRAM command, address, bank

## Operation
- States: INIT, ARBIT, AREF, WRITE, READ. Reset state is INIT.
- INIT: mux init_*. init_end=1 -> ARBIT. init_end is ignored in all other states.
- ARBIT: output NOP, addr 0, bank 0. Decision each cycle:
  - ref_pend -> AREF.
  - Else if only wr_req -> WRITE; only rd_req -> READ.
  - Both wr_req and rd_req -> grant the type opposite to the last granted write/read. last_grant resets to READ, so write wins first.
  - None -> stay in ARBIT.
- AREF / WRITE / READ: mux the owner's cmd/addr/bank. The matching *_end=1 -> ARBIT. *_end from non-owners is ignored.
- Grant pulses: aref_en, wr_en and rd_en are registered. Each is high exactly one cycle: the first cycle in the granted state. Never more than one is high at a time.
- Refresh timer:
  - Held at 0 while in INIT. Otherwise counts 0..REF_CNT_MAX-1 and wraps.
  - At the wrap, ref_pend is set.
  - ref_pend clears in the cycle aref_en is high.
  - A wrap while ref_pend is already 1 leaves it at 1; there is no queuing.
- ref_pend does not abort an active WRITE/READ. The arbiter waits for wr_end/rd_end.
- Reset mid-operation: state -> INIT, timer 0, ref_pend 0, last_grant READ, all grants 0, outputs NOP/0/0.

## Timing
- Reset values: sdram_cmd 4'b0111, sdram_addr 0, sdram_bank 0, aref_en/wr_en/rd_en 0, ref_pend 0.
- Output latency: sdram_* = source mux of state in cycle N, visible in cycle N+1.
- Grant latency: request sampled high in ARBIT at edge k -> state and *_en update at edge k. The owner's commands appear on the pins from edge k+1.
- *_end at edge k -> ARBIT at k. Earliest next grant is at k+1, so there is at least one ARBIT (NOP) cycle between owners.
- ref_pend rises at the edge where the count wraps from REF_CNT_MAX-1 to 0. First rise is REF_CNT_MAX cycles after leaving INIT.
- wr_end and the timer wrap in the same cycle: -> ARBIT, then AREF on the next edge, ahead of any wr_req/rd_req.

## Test plan
- Reset/init: hold s_rst_n=0 -> outputs NOP/0/0, no grants. Release, drive init_cmd patterns, pulse init_end at cycle 200 -> sdram_cmd follows init_cmd with 1-cycle lag; state ARBIT; timer starts.
- Refresh period: REF_CNT_MAX=780, no requests -> ref_pend rises 780 cycles after init_end; aref_en pulses 1 cycle later and ref_pend clears. aref_end after 10 cycles -> next ref_pend 780 cycles after the previous rise.
- Priority: ref_pend, wr_req and rd_req all high in ARBIT -> aref_en first. After aref_end -> wr_en. After wr_end -> rd_en.
- Fairness: wr_req and rd_req held high continuously -> grants alternate W,R,W,R, with one NOP cycle between each.
- Refresh during burst: ref_pend rises mid-WRITE -> WRITE holds until wr_end, then aref_en is granted before a pending rd_req. sdram_cmd shows NOP for exactly one cycle between the two owners.
- Async reset mid-READ: s_rst_n low for 3 cycles -> immediate NOP/0/0, ref_pend 0, rd_en 0. After release, returns to INIT and waits for init_end.
